// File: rtl/eth_bd_pkg.sv
// Shared types for the buffer-descriptor RAM controller: requester IDs,
// access codes and the read-tag carried through the in-flight pipeline.
package eth_bd_pkg;

    typedef enum logic [1:0] {
        REQ_TX   = 2'd0,
        REQ_RX   = 2'd1,
        REQ_HOST = 2'd2
    } req_id_t;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    // Round-robin successor: the requester that gets first look after a winner.
    function automatic req_id_t next_id(req_id_t id);
        case (id)
            REQ_TX:  return REQ_RX;
            REQ_RX:  return REQ_HOST;
            default: return REQ_TX;
        endcase
    endfunction

endpackage

// File: rtl/eth_bd_ram_ctrl_if.sv
// Single-port BD RAM bus: the controller is the master, the RAM instance the slave.
interface eth_bd_ram_ctrl_if;

    logic        ram_ce;
    logic [3:0]  ram_we;
    logic        ram_oe;
    logic [7:0]  ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_dout;

    modport master (output ram_ce, ram_we, ram_oe, ram_addr, ram_di, input ram_dout);
    modport slave  (input ram_ce, ram_we, ram_oe, ram_addr, ram_di, output ram_dout);

endinterface

// File: rtl/eth_bd_ram_ctrl_rr_arb.sv
// Three-way round-robin arbiter (TX -> RX -> host) with a host starvation
// counter that forces a host grant after HOST_MAXWT lost cycles.
module eth_bd_rr_arb
    import eth_bd_pkg::*;
#(
    parameter int HOST_MAXWT = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    tx_req,
    input  logic    rx_req,
    input  logic    host_req,
    output logic    tx_gnt,
    output logic    rx_gnt,
    output logic    host_gnt,
    output logic    gnt_any,
    output req_id_t gnt_id
);

    localparam int CW = $clog2(HOST_MAXWT + 1);

    req_id_t       ptr;
    logic [CW-1:0] host_wait;
    logic          host_forced;

    assign host_forced = host_req && (host_wait >= CW'(HOST_MAXWT));

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        tx_gnt   = 1'b0;
        rx_gnt   = 1'b0;
        host_gnt = 1'b0;
        if (!rst) begin
            if (host_forced) begin
                host_gnt = 1'b1;
            end else begin
                unique case (ptr)
                    REQ_TX: begin
                        if (tx_req)        tx_gnt   = 1'b1;
                        else if (rx_req)   rx_gnt   = 1'b1;
                        else if (host_req) host_gnt = 1'b1;
                    end
                    REQ_RX: begin
                        if (rx_req)        rx_gnt   = 1'b1;
                        else if (host_req) host_gnt = 1'b1;
                        else if (tx_req)   tx_gnt   = 1'b1;
                    end
                    default: begin
                        if (host_req)      host_gnt = 1'b1;
                        else if (tx_req)   tx_gnt   = 1'b1;
                        else if (rx_req)   rx_gnt   = 1'b1;
                    end
                endcase
            end
        end
    end

    assign gnt_any = tx_gnt | rx_gnt | host_gnt;
    assign gnt_id  = rx_gnt ? REQ_RX : (host_gnt ? REQ_HOST : REQ_TX);

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= REQ_TX;
            host_wait <= '0;
        end else begin
            if (gnt_any) ptr <= next_id(gnt_id);
            if (host_gnt)
                host_wait <= '0;
            else if (host_req && (host_wait != CW'(HOST_MAXWT)))
                host_wait <= host_wait + CW'(1);
        end
    end

endmodule

// File: rtl/eth_bd_ram_ctrl.sv
// BD RAM initiator: arbitrates host/TX/RX onto the single RAM port, drives the
// strobes in the grant cycle and returns read data two cycles after the grant.
module eth_bd_ram_ctrl
    import eth_bd_pkg::*;
#(
    parameter int TX_BD_NUM  = 64,
    parameter int HOST_MAXWT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_req,
    input  logic [3:0]            host_we,
    input  logic [7:0]            host_addr,
    input  logic [31:0]           host_wdata,
    output logic                  host_gnt,
    input  logic                  tx_req,
    input  logic [7:0]            tx_addr,
    output logic                  tx_gnt,
    input  logic                  rx_req,
    input  logic [3:0]            rx_we,
    input  logic [7:0]            rx_addr,
    input  logic [31:0]           rx_wdata,
    output logic                  rx_gnt,
    output logic [31:0]           rd_data,
    output logic                  host_rvalid,
    output logic                  tx_rvalid,
    output logic                  rx_rvalid,
    eth_bd_ram_ctrl_if.master     ram
);

    localparam logic [7:0] RX_BASE = 8'(TX_BD_NUM);

    logic        gnt_any;
    req_id_t     gnt_id;
    logic [3:0]  sel_we;
    logic [7:0]  sel_addr;
    logic [31:0] sel_wdata;
    acc_t        acc;
    rd_tag_t     s1, s2;

    eth_bd_rr_arb #(.HOST_MAXWT(HOST_MAXWT)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .tx_req   (tx_req),
        .rx_req   (rx_req),
        .host_req (host_req),
        .tx_gnt   (tx_gnt),
        .rx_gnt   (rx_gnt),
        .host_gnt (host_gnt),
        .gnt_any  (gnt_any),
        .gnt_id   (gnt_id)
    );

    // TX never writes; RX addresses are relative to the end of the TX region and wrap at 256.
    always_comb begin
        sel_we    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt_any) begin
            unique case (gnt_id)
                REQ_TX: sel_addr = tx_addr;
                REQ_RX: begin
                    sel_we    = rx_we;
                    sel_addr  = rx_addr + RX_BASE;
                    sel_wdata = rx_wdata;
                end
                default: begin
                    sel_we    = host_we;
                    sel_addr  = host_addr;
                    sel_wdata = host_wdata;
                end
            endcase
        end
    end

    assign acc = !gnt_any ? ACC_IDLE : ((sel_we == 4'd0) ? ACC_READ : ACC_WRITE);

    // A read keeps ce/oe up through the data cycle even when nothing new is granted.
    assign ram.ram_ce   = !rst && (gnt_any || s1.valid);
    assign ram.ram_oe   = !rst && ((acc == ACC_READ) || s1.valid);
    assign ram.ram_we   = sel_we;
    assign ram.ram_addr = sel_addr;
    assign ram.ram_di   = sel_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            rd_data <= '0;
        end else begin
            s1 <= '{valid: (acc == ACC_READ), id: gnt_id};
            s2 <= s1;
            if (s1.valid) rd_data <= ram.ram_dout;
        end
    end

    assign tx_rvalid   = s2.valid && (s2.id == REQ_TX);
    assign rx_rvalid   = s2.valid && (s2.id == REQ_RX);
    assign host_rvalid = s2.valid && (s2.id == REQ_HOST);

endmodule

// File: tb/tb_eth_bd_ram_ctrl.sv
// Bench for eth_bd_ram_ctrl: behavioural RAM, a transaction-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_eth_bd_ram_ctrl;

    localparam int TX_BD_NUM  = 64;
    localparam int HOST_MAXWT = 4;

    typedef struct {
        int          scyc;
        int          gcyc;
        int          lat;
        logic [31:0] data;
        logic [7:0]  gaddr;
    } acc_res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_req = 1'b0;
    logic [3:0]  host_we = '0;
    logic [7:0]  host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        host_gnt;
    logic        tx_req = 1'b0;
    logic [7:0]  tx_addr = '0;
    logic        tx_gnt;
    logic        rx_req = 1'b0;
    logic [3:0]  rx_we = '0;
    logic [7:0]  rx_addr = '0;
    logic [31:0] rx_wdata = '0;
    logic        rx_gnt;
    logic [31:0] rd_data;
    logic        host_rvalid, tx_rvalid, rx_rvalid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eth_bd_ram_ctrl_if ram ();

    eth_bd_ram_ctrl #(.TX_BD_NUM(TX_BD_NUM), .HOST_MAXWT(HOST_MAXWT)) dut (
        .clk         (clk),
        .rst         (rst),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .tx_req      (tx_req),
        .tx_addr     (tx_addr),
        .tx_gnt      (tx_gnt),
        .rx_req      (rx_req),
        .rx_we       (rx_we),
        .rx_addr     (rx_addr),
        .rx_wdata    (rx_wdata),
        .rx_gnt      (rx_gnt),
        .rd_data     (rd_data),
        .host_rvalid (host_rvalid),
        .tx_rvalid   (tx_rvalid),
        .rx_rvalid   (rx_rvalid),
        .ram         (ram)
    );

    // Behavioural single-port RAM: registered read address, byte-enabled write.
    logic [31:0] ram_mem [256];
    logic [7:0]  ram_raddr = '0;
    logic        ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
            ram_ready <= 1'b1;
        end else if (ram.ram_ce) begin
            for (int b = 0; b < 4; b++)
                if (ram.ram_we[b]) ram_mem[ram.ram_addr][8*b +: 8] <= ram.ram_di[8*b +: 8];
            ram_raddr <= ram.ram_addr;
        end
    end

    assign ram.ram_dout = (ram.ram_ce && ram.ram_oe) ? ram_mem[ram_raddr] : '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic req_of(input int id);
        case (id)
            0:       return tx_req;
            1:       return rx_req;
            default: return host_req;
        endcase
    endfunction

    function automatic logic gnt_of(input int id);
        case (id)
            0:       return tx_gnt;
            1:       return rx_gnt;
            default: return host_gnt;
        endcase
    endfunction

    function automatic logic rvalid_of(input int id);
        case (id)
            0:       return tx_rvalid;
            1:       return rx_rvalid;
            default: return host_rvalid;
        endcase
    endfunction

    // Reference model: who should win, what the RAM port should show, and which
    // read result is due two cycles later.  IDs: 0=TX, 1=RX, 2=host.
    logic [31:0] m_mem [256];
    int          m_ptr  = 0;
    int          m_wait = 0;
    int          s1_id  = -1;
    int          s2_id  = -1;
    logic [31:0] s1_data = '0;
    logic [31:0] s2_data = '0;

    initial begin : model_cmp
        int          win;
        logic [7:0]  a;
        logic [3:0]  w;
        logic [31:0] d;
        logic        rd;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            win = -1;
            a   = '0;
            w   = '0;
            d   = '0;
            if (!rst) begin
                if (host_req && m_wait >= HOST_MAXWT) win = 2;
                else
                    for (int k = 0; k < 3; k++)
                        if (win < 0 && req_of((m_ptr + k) % 3)) win = (m_ptr + k) % 3;
            end
            case (win)
                0: a = tx_addr;
                1: begin
                    a = 8'((TX_BD_NUM + int'(rx_addr)) % 256);
                    w = rx_we;
                    d = rx_wdata;
                end
                2: begin
                    a = host_addr;
                    w = host_we;
                    d = host_wdata;
                end
                default: ;
            endcase
            rd = (win >= 0) && (w == 4'd0);

            check("tx_gnt",   64'(tx_gnt),   64'(win == 0));
            check("rx_gnt",   64'(rx_gnt),   64'(win == 1));
            check("host_gnt", 64'(host_gnt), 64'(win == 2));
            if (win >= 0) begin
                check("ram_addr", 64'(ram.ram_addr), 64'(a));
                check("ram_we",   64'(ram.ram_we),   64'(w));
                if (w != 4'd0) check("ram_di", 64'(ram.ram_di), 64'(d));
            end else begin
                check("ram_we_idle", 64'(ram.ram_we), 64'(0));
            end
            check("ram_ce", 64'(ram.ram_ce), 64'(!rst && (win >= 0 || s1_id >= 0)));
            check("ram_oe", 64'(ram.ram_oe), 64'(!rst && (rd || s1_id >= 0)));
            check("tx_rvalid",   64'(tx_rvalid),   64'(s2_id == 0));
            check("rx_rvalid",   64'(rx_rvalid),   64'(s2_id == 1));
            check("host_rvalid", 64'(host_rvalid), 64'(s2_id == 2));
            if (s2_id >= 0) check("rd_data", 64'(rd_data), 64'(s2_data));

            if (rst) begin
                s1_id  = -1;
                s2_id  = -1;
                m_ptr  = 0;
                m_wait = 0;
            end else begin
                s2_id   = s1_id;
                s2_data = s1_data;
                s1_id   = rd ? win : -1;
                s1_data = m_mem[a];
                if (win >= 0 && w != 4'd0)
                    for (int b = 0; b < 4; b++)
                        if (w[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
                if (win >= 0) m_ptr = (win + 1) % 3;
                if (win == 2)      m_wait = 0;
                else if (host_req) m_wait++;
            end
        end
    end

    // One request/grant handshake; for reads also waits for the matching rvalid.
    task automatic access(input int id, input logic [3:0] we, input logic [7:0] addr,
                          input logic [31:0] wd, output acc_res_t r);
        @(posedge clk);
        #1;
        r.scyc  = cyc;
        r.gcyc  = -1;
        r.lat   = -1;
        r.data  = '0;
        r.gaddr = '0;
        case (id)
            0: begin tx_addr = addr; tx_req = 1'b1; end
            1: begin rx_we = we; rx_addr = addr; rx_wdata = wd; rx_req = 1'b1; end
            default: begin host_we = we; host_addr = addr; host_wdata = wd; host_req = 1'b1; end
        endcase
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt_of(id)) begin
                r.gcyc  = cyc;
                r.gaddr = ram.ram_addr;
                break;
            end
        end
        if (r.gcyc < 0) check("grant_timeout", 64'(id), 64'(-1));
        @(posedge clk);
        #1;
        case (id)
            0:       tx_req   = 1'b0;
            1:       rx_req   = 1'b0;
            default: host_req = 1'b0;
        endcase
        if (r.gcyc >= 0 && (id == 0 || we == 4'd0)) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (rvalid_of(id)) begin
                    r.lat  = cyc - r.gcyc;
                    r.data = rd_data;
                    break;
                end
                @(negedge clk);
            end
            if (r.lat < 0) check("rvalid_timeout", 64'(id), 64'(-1));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin : directed
        acc_res_t r, r_tx, r_rx, r_host;
        int       cnt;

        // Reset held with every requester active: nothing may be granted.
        tx_req   = 1'b1;
        rx_req   = 1'b1;
        host_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt",    64'({tx_gnt, rx_gnt, host_gnt}), 64'(0));
        check("rst_ram_ce", 64'(ram.ram_ce), 64'(0));
        check("rst_rvalid", 64'({tx_rvalid, rx_rvalid, host_rvalid}), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        tx_req   = 1'b0;
        rx_req   = 1'b0;
        host_req = 1'b0;

        // Full-word write then read back.
        access(2, 4'hF, 8'h10, 32'hDEADBEEF, r);
        access(2, 4'h0, 8'h10, 32'h0, r);
        check("host_rd_latency", 64'(r.lat), 64'(2));
        check("host_rd_data",    64'(r.data), 64'(32'hDEADBEEF));

        // Single byte lane write.
        access(2, 4'b0010, 8'h10, 32'h0000AB00, r);
        access(2, 4'h0, 8'h10, 32'h0, r);
        check("byte_wr_data", 64'(r.data), 64'(32'hDEADABEF));

        // Three simultaneous reads: TX, RX, host on successive cycles.
        access(2, 4'hF, 8'h50, 32'h12345678, r);
        fork
            access(0, 4'h0, 8'h10, 32'h0, r_tx);
            access(1, 4'h0, 8'h10, 32'h0, r_rx);
            access(2, 4'h0, 8'h10, 32'h0, r_host);
        join
        check("rr_rx_after_tx",   64'(r_rx.gcyc - r_tx.gcyc),   64'(1));
        check("rr_host_after_tx", 64'(r_host.gcyc - r_tx.gcyc), 64'(2));
        check("rr_tx_lat",   64'(r_tx.lat),   64'(2));
        check("rr_rx_lat",   64'(r_rx.lat),   64'(2));
        check("rr_host_lat", 64'(r_host.lat), 64'(2));
        check("rr_tx_data",   64'(r_tx.data),   64'(32'hDEADABEF));
        check("rr_rx_addr",   64'(r_rx.gaddr),  64'(8'h50));
        check("rr_rx_data",   64'(r_rx.data),   64'(32'h12345678));
        check("rr_host_data", 64'(r_host.data), 64'(32'hDEADABEF));

        // RX address offset wraps modulo 256.
        access(2, 4'hF, 8'h30, 32'hCAFEF00D, r);
        access(1, 4'h0, 8'hF0, 32'h0, r);
        check("rx_wrap_addr", 64'(r.gaddr), 64'(8'h30));
        check("rx_wrap_data", 64'(r.data),  64'(32'hCAFEF00D));
        access(1, 4'hF, 8'h05, 32'hA5A55A5A, r);
        check("rx_wr_addr", 64'(r.gaddr), 64'(8'h45));
        access(2, 4'h0, 8'h45, 32'h0, r);
        check("rx_wr_data", 64'(r.data), 64'(32'hA5A55A5A));

        // Write then read of the same word in consecutive grants.
        access(0, 4'h0, 8'h00, 32'h0, r);
        fork
            access(1, 4'hF, 8'h08, 32'h0BADF00D, r_rx);
            access(2, 4'h0, 8'h48, 32'h0, r_host);
        join
        check("raw_consecutive", 64'(r_host.gcyc - r_rx.gcyc), 64'(1));
        check("raw_data",        64'(r_host.data), 64'(32'h0BADF00D));

        // TX and RX hammering the port while the host competes.
        @(posedge clk);
        #1;
        tx_addr = 8'h10;
        tx_req  = 1'b1;
        rx_we   = 4'h0;
        rx_addr = 8'h10;
        rx_req  = 1'b1;
        repeat (2) @(posedge clk);
        for (int p = 0; p < 3; p++) begin
            @(posedge clk);
            #1;
            host_we   = 4'h0;
            host_addr = 8'h10;
            host_req  = 1'b1;
            @(posedge clk);
            #1;
            host_req = 1'b0;
        end
        access(2, 4'h0, 8'h30, 32'h0, r);
        check("host_starve_bound", 64'((r.gcyc - r.scyc + 1) <= HOST_MAXWT + 1), 64'(1));
        check("host_starve_data",  64'(r.data), 64'(32'hCAFEF00D));
        @(posedge clk);
        #1;
        tx_req = 1'b0;
        rx_req = 1'b0;
        repeat (4) @(posedge clk);

        // Reset in the data cycle of a read drops it.
        #1;
        host_we   = 4'h0;
        host_addr = 8'h10;
        host_req  = 1'b1;
        @(negedge clk);
        check("pre_rst_gnt", 64'(host_gnt), 64'(1));
        @(posedge clk);
        #1;
        host_req = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (host_rvalid) cnt++;
        end
        check("rst_drops_read", 64'(cnt), 64'(0));
        access(2, 4'h0, 8'h10, 32'h0, r);
        check("post_rst_data", 64'(r.data), 64'(32'hDEADABEF));

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
